scanout_dma: RTL
================

SCANOUT_DMA -- requirements
Module: scanout_dma

Interface
REQ-001 SHALL have parameter BURST, default 16, giving the maximum beats per read request (1..256).
REQ-002 SHALL have parameter FIFOW, default 10, giving the width of fifofree.
REQ-003 SHALL use one clock; reset is asynchronous and active-high. Ports:
  clk  in  1  sole clock
  reset  in  1  asynchronous, active-high
  dmastart  in  1  frame-start pulse (single cycle)
  base  in  32  framebuffer byte address, sampled at dmastart
  stride  in  16  line pitch in bytes, sampled at dmastart
  hact  in  16  active pixels per line (even), sampled at dmastart
  vact  in  16  active lines, sampled at dmastart
  fifofree  in  FIFOW  free 48-bit words in the downstream pixel FIFO
  rdreq  out  1  read request valid
  rdaddr  out  32  burst byte address
  rdlen  out  8  burst beats minus one
  rdack  in  1  request accepted
  rddata  in  64  read beat, two XRGB pixels, low pixel first
  rdvalid  in  1  read beat valid, in request order
  dmado  out  48  pixel pair {rddata[55:32], rddata[23:0]}
  dmavalid  out  1  dmado valid
  busy  out  1  frame in progress
  err  out  1  sticky: rdvalid with no outstanding beats

Function
REQ-004 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-005 In IDLE, dmastart with hact!=0 and vact!=0 SHALL latch the inputs, set line=0, lineaddr=base, addr=base, beats-left-in-line=hact/2, and enter ISSUE; otherwise SHALL remain in IDLE.
REQ-006 In ISSUE, a burst SHALL be len=min(BURST, beats left in line); the burst SHALL NOT cross a line.
REQ-007 rdreq SHALL assert only when fifofree >= outstanding + len, where outstanding is the count of accepted but unreturned beats.
REQ-008 rdaddr, rdlen, rdreq SHALL hold stable from assertion until the cycle rdack is high.
REQ-009 On rdack: addr += 8*len; beats-left -= len; outstanding += len.
REQ-010 When beats-left reaches 0 and the line is not the last: lineaddr += stride; addr = new lineaddr; beats-left = hact/2.
REQ-011 After the last burst of the last line is acked, the block SHALL enter DRAIN.
REQ-012 DRAIN -> IDLE when outstanding==0.
REQ-013 Each rdvalid beat SHALL decrement outstanding (same-cycle rdack and rdvalid net correctly) and produce dmavalid exactly one cycle later with dmado as in REQ-003.
REQ-014 busy SHALL be high in ISSUE and DRAIN.
REQ-015 dmastart while not in IDLE SHALL restart the frame per REQ-005; beats outstanding at that instant SHALL be moved to a drop counter and discarded without dmavalid.
REQ-016 A pending rdreq SHALL NOT be withdrawn by a restart until acked.
REQ-017 rdvalid with outstanding==0 and drop==0 SHALL set err, which clears only on reset; the beat SHALL be discarded.
REQ-018 Address arithmetic SHALL be 32-bit modulo 2^32.
REQ-019 outstanding SHALL be FIFOW+1 bits wide.

Reset
REQ-020 On reset: state=IDLE; rdreq=0; rdaddr=0; rdlen=0; dmado=0; dmavalid=0; busy=0; err=0; all counters 0.
REQ-021 Reset mid-frame SHALL abandon the frame; beats arriving after reset release SHALL set err.

Verification
REQ-022 base=0x1000, stride=64, hact=4, vact=2, fifofree=512, memory returns 2 cycles after ack -> requests (0x1000,len1), (0x1040,len1); 4 dmavalid beats; busy falls after the 4th beat.
REQ-023 hact=40, vact=1, BURST=16 -> requests (base,rdlen 15), (base+128,rdlen 3); 20 dmavalid beats.
REQ-024 hact=40, fifofree held at 10 -> rdreq stays low; when fifofree is raised to 16, first request issues within 2 cycles.
REQ-025 Restart via dmastart with 8 beats outstanding -> those 8 beats produce no dmavalid; the new frame starts at the new base; err stays 0.
REQ-026 hact=0 with dmastart -> no rdreq, busy stays 0; an unsolicited rdvalid -> err=1 until reset.
REQ-027 Reset asserted during ISSUE -> all outputs 0 in the same cycle, asynchronously; state=IDLE.

Source files
------------

// File: rtl/scanout_dma.sv
// scanout_dma: fetches an active-video frame from memory as bounded read
// bursts and streams the returned pixel pairs to a downstream pixel FIFO.
//
// Ports
//   clk, reset            sole clock, asynchronous active-high reset
//   dmastart              frame-start pulse; base/stride/hact/vact sampled here
//   fifofree              free 48-bit words in the downstream pixel FIFO
//   rdreq/rdaddr/rdlen    read request (byte address, beats minus one)
//   rdack                 request accepted
//   rddata/rdvalid        returned beats, in request order
//   dmado/dmavalid        pixel pair {rddata[55:32], rddata[23:0]}, one cycle later
//   busy                  frame in progress
//   err                   sticky: beat returned with nothing outstanding
module scanout_dma #(
  parameter int unsigned BURST = 16,
  parameter int unsigned FIFOW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dmastart,
  input  logic [31:0]      base,
  input  logic [15:0]      stride,
  input  logic [15:0]      hact,
  input  logic [15:0]      vact,
  input  logic [FIFOW-1:0] fifofree,
  output logic             rdreq,
  output logic [31:0]      rdaddr,
  output logic [7:0]       rdlen,
  input  logic             rdack,
  input  logic [63:0]      rddata,
  input  logic             rdvalid,
  output logic [47:0]      dmado,
  output logic             dmavalid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned OW = FIFOW + 1;
  localparam int unsigned NW = ((OW > 16) ? OW : 16) + 1;
  localparam logic [15:0] BURST_L = 16'(BURST);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [15:0]   stride_q, stride_d;
  logic [15:0]   hbeats_q, hbeats_d;
  logic [15:0]   vlast_q, vlast_d;
  logic [15:0]   line_q, line_d;
  logic [31:0]   lineaddr_q, lineaddr_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   left_q, left_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic          stale_q, stale_d;
  logic          rdreq_q, rdreq_d;
  logic [31:0]   rdaddr_q, rdaddr_d;
  logic [7:0]    rdlen_q, rdlen_d;
  logic [47:0]   dmado_q, dmado_d;
  logic          dmavalid_q, dmavalid_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  // Burst sizing and request accounting
  logic [15:0]   len_c, req_len_c;
  logic          fifo_ok_c, ack_c, live_ack_c, stale_ack_c;
  logic          take_drop_c, take_out_c, bad_c;
  logic          restart_c, start_ok_c, last_burst_c;
  logic [OW-1:0] outst_n_c, drop_n_c;
  logic          unused_ok_c;

  assign len_c       = (left_q > BURST_L) ? BURST_L : left_q;
  assign req_len_c   = 16'(rdlen_q) + 16'd1;
  assign fifo_ok_c   = NW'(fifofree) >= (NW'(outst_q) + NW'(len_c));
  assign ack_c       = rdreq_q & rdack;
  // A request issued before a restart belongs to the abandoned frame.
  assign live_ack_c  = ack_c & ~stale_q;
  assign stale_ack_c = ack_c & stale_q;
  // Beats return in request order, so abandoned beats are consumed first.
  assign take_drop_c = rdvalid & (drop_q != '0);
  assign take_out_c  = rdvalid & (drop_q == '0) & (outst_q != '0);
  assign bad_c       = rdvalid & (drop_q == '0) & (outst_q == '0);
  assign outst_n_c   = outst_q + (live_ack_c ? OW'(req_len_c) : '0) - OW'(take_out_c);
  assign drop_n_c    = drop_q + (stale_ack_c ? OW'(req_len_c) : '0) - OW'(take_drop_c);
  assign restart_c   = dmastart & (state_q != IDLE);
  // hact is in pixels and must give at least one 2-pixel beat.
  assign start_ok_c  = dmastart & (hact[15:1] != 15'd0) & (vact != 16'd0);
  assign last_burst_c = (left_q == req_len_c);
  assign unused_ok_c = ^{rddata[63:56], rddata[31:24], hact[0]};

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    hbeats_d   = hbeats_q;
    vlast_d    = vlast_q;
    line_d     = line_q;
    lineaddr_d = lineaddr_q;
    addr_d     = addr_q;
    left_d     = left_q;
    outst_d    = outst_n_c;
    drop_d     = drop_n_c;
    stale_d    = stale_q;
    rdreq_d    = rdreq_q;
    rdaddr_d   = rdaddr_q;
    rdlen_d    = rdlen_q;
    dmado_d    = dmado_q;
    dmavalid_d = take_out_c;
    err_d      = err_q | bad_c;

    if (ack_c) begin
      rdreq_d = 1'b0;
      stale_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
      end
      ISSUE: begin
        if (live_ack_c) begin
          if (last_burst_c) begin
            if (line_q == vlast_q) begin
              state_d = DRAIN;
            end else begin
              line_d     = line_q + 16'd1;
              lineaddr_d = lineaddr_q + 32'(stride_q);
              addr_d     = lineaddr_q + 32'(stride_q);
              left_d     = hbeats_q;
            end
          end else begin
            addr_d = addr_q + {13'd0, req_len_c, 3'd0};
            left_d = left_q - req_len_c;
          end
        end else if (!rdreq_q && (left_q != 16'd0) && fifo_ok_c && !dmastart) begin
          rdreq_d  = 1'b1;
          rdaddr_d = addr_q;
          rdlen_d  = 8'(len_c - 16'd1);
        end
      end
      DRAIN: begin
        if (outst_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Restart: everything still in flight is discarded on return.
    if (restart_c) begin
      drop_d  = drop_n_c + outst_n_c;
      outst_d = '0;
      if (rdreq_q && !ack_c) stale_d = 1'b1;
      if (!start_ok_c) state_d = IDLE;
    end

    if (start_ok_c) begin
      state_d    = ISSUE;
      stride_d   = stride;
      hbeats_d   = {1'b0, hact[15:1]};
      vlast_d    = vact - 16'd1;
      line_d     = 16'd0;
      lineaddr_d = base;
      addr_d     = base;
      left_d     = {1'b0, hact[15:1]};
    end

    if (take_out_c) dmado_d = {rddata[55:32], rddata[23:0]};
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      stride_q   <= '0;
      hbeats_q   <= '0;
      vlast_q    <= '0;
      line_q     <= '0;
      lineaddr_q <= '0;
      addr_q     <= '0;
      left_q     <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      stale_q    <= 1'b0;
      rdreq_q    <= 1'b0;
      rdaddr_q   <= '0;
      rdlen_q    <= '0;
      dmado_q    <= '0;
      dmavalid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stride_q   <= stride_d;
      hbeats_q   <= hbeats_d;
      vlast_q    <= vlast_d;
      line_q     <= line_d;
      lineaddr_q <= lineaddr_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      stale_q    <= stale_d;
      rdreq_q    <= rdreq_d;
      rdaddr_q   <= rdaddr_d;
      rdlen_q    <= rdlen_d;
      dmado_q    <= dmado_d;
      dmavalid_q <= dmavalid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign rdreq    = rdreq_q;
  assign rdaddr   = rdaddr_q;
  assign rdlen    = rdlen_q;
  assign dmado    = dmado_q;
  assign dmavalid = dmavalid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
